// File: rtl/nota_voz.sv
// nota_voz: wavetable voice with phase accumulator and attack/sustain/release envelope
module nota_voz #(
  parameter int ACC_W    = 24,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 8,
  parameter int ENV_W    = 8,
  parameter int ATK_STEP = 16,
  parameter int REL_STEP = 8,
  parameter int ENV_DIV  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ativado,
  input  logic [ACC_W-1:0]  incr,
  output logic [IDX_W-1:0]  sample_idx,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] saida,
  output logic              ativo
);
  localparam logic [1:0] IDLE = 2'd0, ATTACK = 2'd1, SUSTAIN = 2'd2, RELEASE = 2'd3;
  localparam int CW = ENV_DIV > 1 ? $clog2(ENV_DIV) : 1;
  localparam logic [ENV_W:0] ENV_MAX = (ENV_W+1)'((1 << ENV_W) - 1);
  localparam logic [ENV_W:0] ATK = (ENV_W+1)'(ATK_STEP);
  localparam logic [ENV_W:0] REL = (ENV_W+1)'(REL_STEP);
  logic [1:0] state, nxt;
  logic [ACC_W-1:0] acc;
  logic [ENV_W-1:0] env, env_n;
  logic [CW-1:0] cnt;
  logic [ENV_W:0] up, dn;
  logic [DATA_W+ENV_W-1:0] prod;
  logic tick;
  assign tick = cnt == CW'(ENV_DIV - 1);
  assign sample_idx = acc[ACC_W-1 -: IDX_W];
  assign ativo = state != IDLE;
  assign up = {1'b0, env} + ATK;
  assign dn = {1'b0, env} - REL;
  assign prod = sample_in * env;
  // gate changes take priority over envelope steps; steps saturate at both ends
  always_comb begin
    nxt = state;
    env_n = env;
    case (state)
      IDLE: if (ativado) begin
        nxt = ATTACK;
        env_n = '0;
      end
      ATTACK: if (!ativado) nxt = RELEASE;
        else if (tick) begin
          nxt = up >= ENV_MAX ? SUSTAIN : ATTACK;
          env_n = up >= ENV_MAX ? ENV_MAX[ENV_W-1:0] : up[ENV_W-1:0];
        end
      SUSTAIN: begin
        env_n = ENV_MAX[ENV_W-1:0];
        if (!ativado) nxt = RELEASE;
      end
      default: if (ativado) nxt = ATTACK;
        else if (tick) begin
          nxt = {1'b0, env} <= REL ? IDLE : RELEASE;
          env_n = {1'b0, env} <= REL ? '0 : dn[ENV_W-1:0];
        end
    endcase
  end
  // state, phase, envelope tick and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      env <= '0;
      cnt <= '0;
      saida <= '0;
    end else begin
      state <= nxt;
      env <= env_n;
      cnt <= tick ? '0 : cnt + 1'b1;
      acc <= (state == IDLE || nxt == IDLE) ? '0 : acc + incr;
      saida <= state == IDLE ? '0 : prod[DATA_W+ENV_W-1 -: DATA_W];
    end
endmodule

// File: doc/nota_voz.md
NOTA_VOZ -- requirements
Module: nota_voz

Interface
REQ-001 SHALL: parameter ACC_W, default 24, phase accumulator width.
REQ-002 SHALL: parameter IDX_W, default 5, wavetable index width (2^IDX_W entries).
REQ-003 SHALL: parameter DATA_W, default 8, sample and output width (unsigned).
REQ-004 SHALL: parameter ENV_W, default 8, envelope width; full scale ENV_MAX = 2^ENV_W-1.
REQ-005 SHALL: parameter ATK_STEP, default 16, envelope increment per tick.
REQ-006 SHALL: parameter REL_STEP, default 8, envelope decrement per tick.
REQ-007 SHALL: parameter ENV_DIV, default 4, clock cycles per envelope tick (>=1).
REQ-008 SHALL: clk  in  1  single clock; all state on rising edge.
REQ-009 SHALL: rst  in  1  reset, asynchronous, active-high.
REQ-010 SHALL: ativado  in  1  note gate (high = key held).
REQ-011 SHALL: incr  in  ACC_W  phase increment per cycle (pitch).
REQ-012 SHALL: sample_idx  out  IDX_W  wavetable address to external synchronous sample ROM.
REQ-013 SHALL: sample_in  in  DATA_W  ROM data, valid one cycle after sample_idx.
REQ-014 SHALL: saida  out  DATA_W  enveloped sample, registered.
REQ-015 SHALL: ativo  out  1  high whenever state != IDLE.

Function
REQ-016 SHALL: phase accumulator acc: in non-IDLE states acc <= acc + incr modulo 2^ACC_W every cycle; in IDLE acc held at 0.
REQ-017 SHALL: sample_idx = acc[ACC_W-1 -: IDX_W], combinational from acc; wraps naturally with acc.
REQ-018 SHALL: saida <= top DATA_W bits of the (DATA_W+ENV_W)-bit product sample_in*env, i.e. (sample_in*env) >> ENV_W; latency acc edge -> saida = 2 cycles.
REQ-019 SHALL: incr changes take effect on the next accumulate; incr=0 freezes sample_idx.
REQ-020 SHALL: envelope tick counter free-runs 0..ENV_DIV-1; tick asserted on the cycle counter == ENV_DIV-1; env changes only on tick.
REQ-021 SHALL: states IDLE, ATTACK, SUSTAIN, RELEASE; gate transitions evaluated every cycle, independent of tick.
REQ-022 SHALL: IDLE & ativado -> ATTACK; acc restarts from 0, env from 0.
REQ-023 SHALL: ATTACK on tick: env+ATK_STEP >= ENV_MAX -> env=ENV_MAX and SUSTAIN same edge; else env += ATK_STEP.
REQ-024 SHALL: SUSTAIN: env=ENV_MAX; !ativado -> RELEASE.
REQ-025 SHALL: ATTACK & !ativado -> RELEASE from current env (no jump).
REQ-026 SHALL: RELEASE on tick: env <= REL_STEP -> env=0 and IDLE same edge; else env -= REL_STEP.
REQ-027 SHALL: RELEASE & ativado -> ATTACK from current env; phase NOT reset (retrigger).
REQ-028 SHALL: gate edge and tick on same cycle: state transition wins; no env step that cycle.
REQ-029 SHALL: env never overflows or underflows (saturating arithmetic, ENV_W+1-bit intermediates).
REQ-030 SHALL: in IDLE saida registers 0 regardless of sample_in.

Reset
REQ-031 SHALL: rst high clears immediately, without clock: state=IDLE, acc=0, env=0, tick counter=0, saida=0, ativo=0.
REQ-032 SHALL: reset mid-note silences output at once; after release of rst the note restarts only on ativado high in IDLE.

Verification
REQ-033 SHALL: ativado high in SUSTAIN, pulse rst between clock edges -> saida=0, ativo=0 before next edge; stays IDLE with ativado low.
REQ-034 SHALL: incr=2^19, ativado held -> sample_idx steps 0,1,2..31 one per cycle, returns to 0 on cycle 32.
REQ-035 SHALL: defaults, ativado rises -> env 16,32..240 on ticks 1-15, 255 and SUSTAIN on tick 16 (64 cycles).
REQ-036 SHALL: from SUSTAIN, ativado low -> env 247,239..7 then 0 and IDLE on tick 32; ativo falls on that edge.
REQ-037 SHALL: during RELEASE at env=127, ativado high -> ATTACK, next tick env=143; sample_idx continues without reset.
REQ-038 SHALL: sample_in=200 constant, SUSTAIN (env=255) -> saida=199; env=128 -> saida=100.
